// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline shares the port with
// load returns, which are buffered in a small in-order FIFO when they lose.
module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_valid,
    input  logic [4:0]               pipe_rd,
    input  logic [XLEN-1:0]          pipe_data,
    output logic                     pipe_ready,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    output logic                     mem_ready,
    output logic                     rf_wr_en,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_data,
    input  logic [4:0]               chk_rd,
    output logic                     chk_hit,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [4:0]      ent_rd    [DEPTH];
    logic [XLEN-1:0] ent_data  [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic            full;
    logic            empty;
    logic            pipe_wr;
    logic            mem_wr;
    logic            push;
    logic            pop;
    logic            sel_wr;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign full       = (fifo_level == LW'(DEPTH));
    assign empty      = (fifo_level == '0);
    assign pipe_ready = !full;
    assign mem_ready  = !full;

    // Transfers to x0 are accepted but never reach the port or the FIFO.
    assign pipe_wr = pipe_valid && pipe_ready && (pipe_rd != 5'd0);
    assign mem_wr  = mem_valid  && mem_ready  && (mem_rd  != 5'd0);

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        sel_wr   = 1'b0;
        sel_rd   = 5'd0;
        sel_data = '0;
        if (full) begin
            sel_wr   = 1'b1;
            sel_rd   = ent_rd[rd_ptr];
            sel_data = ent_data[rd_ptr];
            pop      = 1'b1;
        end else if (pipe_wr) begin
            sel_wr   = 1'b1;
            sel_rd   = pipe_rd;
            sel_data = pipe_data;
            push     = mem_wr;
        end else if (!empty) begin
            sel_wr   = 1'b1;
            sel_rd   = ent_rd[rd_ptr];
            sel_data = ent_data[rd_ptr];
            pop      = 1'b1;
            push     = mem_wr;
        end else if (mem_wr) begin
            sel_wr   = 1'b1;
            sel_rd   = mem_rd;
            sel_data = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            ent_valid  <= '0;
        end else begin
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            // A push never targets the slot being popped: it only happens when not full.
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_rd[wr_ptr]    <= mem_rd;
                ent_data[wr_ptr]  <= mem_data;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en <= 1'b0;
            rf_rd    <= 5'd0;
            rf_data  <= '0;
        end else begin
            rf_wr_en <= sel_wr;
            if (sel_wr) begin
                rf_rd   <= sel_rd;
                rf_data <= sel_data;
            end
        end
    end

    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == chk_rd)) chk_hit = 1'b1;
        end
        if (chk_rd == 5'd0) chk_hit = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2): bypass, collision, full drain,
// x0 filtering, pipe-over-FIFO priority and mid-operation reset.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  chk_rd;
    logic        chk_hit;
    logic [1:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_ready (pipe_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .chk_rd     (chk_rd),
        .chk_hit    (chk_hit),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid = 1'b0;
        pipe_rd    = 5'd0;
        pipe_data  = 32'd0;
        mem_valid  = 1'b0;
        mem_rd     = 5'd0;
        mem_data   = 32'd0;
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_data  = pd;
        mem_valid  = mv;
        mem_rd     = mrd;
        mem_data   = md;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] rd, input logic [31:0] d,
                             input logic [1:0] lvl);
        check({tag, "_wr_en"}, 32'(rf_wr_en), 32'd1);
        check({tag, "_rd"}, 32'(rf_rd), 32'(rd));
        check({tag, "_data"}, rf_data, d);
        check({tag, "_level"}, 32'(fifo_level), 32'(lvl));
    endtask

    task automatic expect_hit(input string tag, input logic [4:0] rd, input logic exp);
        chk_rd = rd;
        #1;
        check(tag, 32'(chk_hit), 32'(exp));
        chk_rd = 5'd0;
    endtask

    initial begin
        rst    = 1'b1;
        chk_rd = 5'd0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_rd", 32'(rf_rd), 32'd0);
        check("rst_data", rf_data, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_pipe_ready", 32'(pipe_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_chk_hit", 32'(chk_hit), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_wr_en", 32'(rf_wr_en), 32'd0);
            check("idle_level", 32'(fifo_level), 32'd0);
            check("idle_pipe_ready", 32'(pipe_ready), 32'd1);
            check("idle_mem_ready", 32'(mem_ready), 32'd1);
        end

        // Bypass with empty FIFO
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("byp_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        idle();
        expect_wr("byp", 5'd5, 32'hDEADBEEF, 2'd0);
        expect_hit("byp_chk5", 5'd5, 1'b0);
        tick();
        check("hold_wr_en", 32'(rf_wr_en), 32'd0);
        check("hold_rd", 32'(rf_rd), 32'd5);
        check("hold_data", rf_data, 32'hDEADBEEF);

        // Collision: pipe wins, load buffered, then drained on idle cycle
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        tick();
        idle();
        expect_wr("col_pipe", 5'd3, 32'h11, 2'd1);
        expect_hit("col_chk7", 5'd7, 1'b1);
        expect_hit("col_chk3", 5'd3, 1'b0);
        tick();
        expect_wr("col_mem", 5'd7, 32'h22, 2'd0);
        expect_hit("col_chk7_after", 5'd7, 1'b0);
        tick();
        check("col_idle_wr_en", 32'(rf_wr_en), 32'd0);

        // Full drain: pipe x1..x4, loads x8/x9 alongside x3/x4, stalled load x20
        drive(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'd0);
        tick();
        expect_wr("fd_x1", 5'd1, 32'h101, 2'd0);
        drive(1'b1, 5'd2, 32'h102, 1'b0, 5'd0, 32'd0);
        tick();
        expect_wr("fd_x2", 5'd2, 32'h102, 2'd0);
        drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd8, 32'h80);
        tick();
        expect_wr("fd_x3", 5'd3, 32'h103, 2'd1);
        drive(1'b1, 5'd4, 32'h104, 1'b1, 5'd9, 32'h90);
        #1;
        check("fd_pipe_ready_l1", 32'(pipe_ready), 32'd1);
        check("fd_mem_ready_l1", 32'(mem_ready), 32'd1);
        tick();
        expect_wr("fd_x4", 5'd4, 32'h104, 2'd2);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hA0);
        #1;
        check("fd_pipe_ready_full", 32'(pipe_ready), 32'd0);
        check("fd_mem_ready_full", 32'(mem_ready), 32'd0);
        expect_hit("fd_chk9", 5'd9, 1'b1);
        expect_hit("fd_chk20", 5'd20, 1'b0);
        tick();
        expect_wr("fd_x8", 5'd8, 32'h80, 2'd1);
        #1;
        check("fd_mem_ready_l1b", 32'(mem_ready), 32'd1);
        tick();
        idle();
        expect_wr("fd_x9", 5'd9, 32'h90, 2'd1);
        expect_hit("fd_chk20_pushed", 5'd20, 1'b1);
        tick();
        expect_wr("fd_x20", 5'd20, 32'hA0, 2'd0);
        tick();
        check("fd_idle_wr_en", 32'(rf_wr_en), 32'd0);

        // x0 filter: pipe rd=0 accepted while FIFO head x6 is written
        drive(1'b1, 5'd2, 32'h21, 1'b1, 5'd6, 32'h66);
        tick();
        expect_wr("x0_setup", 5'd2, 32'h21, 2'd1);
        drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
        #1;
        check("x0_pipe_ready", 32'(pipe_ready), 32'd1);
        tick();
        idle();
        expect_wr("x0_head", 5'd6, 32'h66, 2'd0);
        tick();
        check("x0_idle_wr_en", 32'(rf_wr_en), 32'd0);
        check("x0_idle_rd", 32'(rf_rd), 32'd6);

        // Pipe beats a non-empty FIFO; both loads kept in order
        drive(1'b1, 5'd10, 32'hA1, 1'b1, 5'd11, 32'hB1);
        tick();
        expect_wr("pr_x10", 5'd10, 32'hA1, 2'd1);
        drive(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hB3);
        tick();
        idle();
        expect_wr("pr_x12", 5'd12, 32'hA2, 2'd2);
        expect_hit("pr_chk11", 5'd11, 1'b1);
        expect_hit("pr_chk13", 5'd13, 1'b1);
        expect_hit("pr_chk12", 5'd12, 1'b0);
        tick();
        expect_wr("pr_x11", 5'd11, 32'hB1, 2'd1);
        expect_hit("pr_chk11_popped", 5'd11, 1'b0);
        expect_hit("pr_chk13_still", 5'd13, 1'b1);
        tick();
        expect_wr("pr_x13", 5'd13, 32'hB3, 2'd0);

        // Reset with two buffered loads
        drive(1'b1, 5'd14, 32'hE1, 1'b1, 5'd15, 32'hF1);
        tick();
        drive(1'b1, 5'd16, 32'hE3, 1'b1, 5'd17, 32'hF3);
        tick();
        idle();
        expect_wr("rs_x16", 5'd16, 32'hE3, 2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_level", 32'(fifo_level), 32'd0);
        check("rs_wr_en", 32'(rf_wr_en), 32'd0);
        check("rs_rd", 32'(rf_rd), 32'd0);
        check("rs_data", rf_data, 32'd0);
        check("rs_pipe_ready", 32'(pipe_ready), 32'd1);
        expect_hit("rs_chk15", 5'd15, 1'b0);
        expect_hit("rs_chk17", 5'd17, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rs_after_wr_en", 32'(rf_wr_en), 32'd0);
            check("rs_after_level", 32'(fifo_level), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
